// File: rtl/onchip_mem_arb_pkg.sv
// rtl/onchip_mem_arb_pkg.sv - shared defaults, master id and read tag types for the on-chip RAM arbiter
package onchip_mem_arb_pkg;

    localparam int ADDR_W_DEF    = 15;
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_DEPTH_DEF = 16640;
    localparam int MAX_HOLD_DEF  = 4;

    // Wide enough for any hold limit in 1..15.
    localparam int HOLD_CNT_W    = 4;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

    // One entry of the read-return pipeline: which master gets the data and
    // whether the RAM output must be replaced by zero.
    typedef struct packed {
        logic       valid;
        master_id_t id;
        logic       oor;
    } rd_tag_t;

    function automatic master_id_t other_id(input master_id_t id);
        return (id == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/onchip_rr_hold_arb.sv
// rtl/onchip_rr_hold_arb.sv - two-requester round-robin arbiter with a bounded hold window
module onchip_rr_hold_arb
    import onchip_mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    output logic gnt_valid,
    output logic gnt_id
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD);

    master_id_t            last_id;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    // Set when the current back-to-back run started with the bus uncontested;
    // only such a run may keep the bus against a newly arriving requester.
    logic                  hold_ok;
    logic                  keep;
    logic                  repeat_gnt;
    master_id_t            sel;

    // Grant selection: lone requester wins; on a tie the other master wins
    // unless the current owner is inside its hold window.
    always_comb begin
        sel  = M0;
        keep = hold_ok && (hold_cnt != '0) && (hold_cnt < HOLD_LIMIT);
        if (req0 && req1) begin
            sel = keep ? last_id : other_id(last_id);
        end else if (req1) begin
            sel = M1;
        end
    end

    assign gnt_valid  = req0 | req1;
    assign gnt_id     = sel;
    assign repeat_gnt = (sel == last_id) && (hold_cnt != '0);

    // Track the owner of the current run and its length; an idle cycle ends the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_id  <= M1;
            hold_cnt <= '0;
            hold_ok  <= 1'b0;
        end else if (gnt_valid) begin
            if (repeat_gnt) begin
                if (hold_cnt < HOLD_LIMIT) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else begin
                hold_cnt <= {{(HOLD_CNT_W-1){1'b0}}, 1'b1};
                hold_ok  <= (sel == M0) ? ~req1 : ~req0;
            end
            last_id <= sel;
        end else begin
            hold_cnt <= '0;
            hold_ok  <= 1'b0;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - shares the single-port on-chip RAM between m0 and m1; ONCHIP_MEM_ARB_STATS_EN adds counters
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int MAX_HOLD  = MAX_HOLD_DEF
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,

    output logic                oor_err
`ifdef ONCHIP_MEM_ARB_STATS_EN
   ,input  logic                stat_clr,
    output logic [31:0]         stat_grant0,
    output logic [31:0]         stat_grant1,
    output logic [31:0]         stat_stall
`endif
);

    localparam int              BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    logic              req0;
    logic              req1;
    logic              gnt_valid;
    logic              gnt_id;
    logic              grant_en;

    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;
    logic              sel_illegal;

    rd_tag_t           tag_d;
    rd_tag_t           tag_q;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] hold0_q;
    logic [DATA_W-1:0] hold1_q;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    onchip_rr_hold_arb #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Nothing is accepted while reset is asserted, even with requests pending.
    assign grant_en = gnt_valid & reset_n;

    // Route the granted master's command towards the RAM.
    always_comb begin
        sel_read  = m0_read;
        sel_write = m0_write;
        sel_addr  = m0_address;
        sel_be    = m0_byteenable;
        sel_wdata = m0_writedata;
        if (gnt_id) begin
            sel_read  = m1_read;
            sel_write = m1_write;
            sel_addr  = m1_address;
            sel_be    = m1_byteenable;
            sel_wdata = m1_writedata;
        end
    end

    // Read and write together behaves as a write and never flags oor_err.
    assign sel_illegal = sel_read & sel_write;
    assign sel_oor     = {1'b0, sel_addr} >= DEPTH_L;

    assign m0_waitrequest = ~(grant_en & ~gnt_id);
    assign m1_waitrequest = ~(grant_en &  gnt_id);

    assign mem_address    = sel_addr;
    assign mem_byteenable = sel_be;
    assign mem_writedata  = sel_wdata;
    assign mem_chipselect = grant_en & ~sel_oor;
    assign mem_write      = grant_en & ~sel_oor & sel_write;
    assign mem_clken      = 1'b1;

    // Tag for the read accepted this cycle; out-of-range reads still get a tag.
    always_comb begin
        tag_d       = '0;
        tag_d.valid = grant_en & sel_read & ~sel_write;
        tag_d.id    = master_id_t'(gnt_id);
        tag_d.oor   = sel_oor;
    end

    // One-stage tag pipeline matching the RAM's single-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign hit0   = tag_q.valid & (tag_q.id == M0);
    assign hit1   = tag_q.valid & (tag_q.id == M1);
    assign rd_val = tag_q.oor ? '0 : mem_readdata;

    assign m0_readdatavalid = hit0;
    assign m1_readdatavalid = hit1;
    assign m0_readdata      = hit0 ? rd_val : hold0_q;
    assign m1_readdata      = hit1 ? rd_val : hold1_q;

    // Keep each master's last returned word so its readdata stays put between returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            if (hit0) begin
                hold0_q <= rd_val;
            end
            if (hit1) begin
                hold1_q <= rd_val;
            end
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oor_err <= 1'b0;
        end else if (grant_en && sel_oor && !sel_illegal) begin
            oor_err <= 1'b1;
        end
    end

`ifdef ONCHIP_MEM_ARB_STATS_EN
    // Accepted-transfer and contention counters; wrap freely, clear on stat_clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_grant0 <= '0;
            stat_grant1 <= '0;
            stat_stall  <= '0;
        end else if (stat_clr) begin
            stat_grant0 <= '0;
            stat_grant1 <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant_en && !gnt_id) begin
                stat_grant0 <= stat_grant0 + 32'd1;
            end
            if (grant_en && gnt_id) begin
                stat_grant1 <= stat_grant1 + 32'd1;
            end
            if (req0 && req1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

    // A stalled master must present the same command until it is accepted.
    a_m0_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (req0 && m0_waitrequest) |=> ($stable(m0_read) && $stable(m0_write) && $stable(m0_address)
                                      && $stable(m0_byteenable) && $stable(m0_writedata)));

    a_m1_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (req1 && m1_waitrequest) |=> ($stable(m1_read) && $stable(m1_write) && $stable(m1_address)
                                      && $stable(m1_byteenable) && $stable(m1_writedata)));

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - self-checking bench for onchip_mem_arbiter against a behavioural model
module tb_onchip_mem_arbiter;

    localparam int DEPTH    = 16640;
    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [14:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        oor_err;
`ifdef ONCHIP_MEM_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_grant0, stat_grant1, stat_stall;
    int          exp_sg0, exp_sg1, exp_st;
`endif

    always #5 clk = ~clk;

    onchip_mem_arbiter #(
        .ADDR_W(15), .DATA_W(32), .MEM_DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .oor_err(oor_err)
`ifdef ONCHIP_MEM_ARB_STATS_EN
       ,.stat_clr(stat_clr), .stat_grant0(stat_grant0),
        .stat_grant1(stat_grant1), .stat_stall(stat_stall)
`endif
    );

    // RAM attached to the DUT: registered read, byte-lane writes.
    logic [31:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [14:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;

    req_t        q0[$];
    req_t        q1[$];
    logic [31:0] exp_mem [0:DEPTH-1];

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state: owner of the current run of back-to-back grants,
    // its length (0 after an idle cycle), and whether it began uncontested.
    int          owner;
    int          run;
    bit          earned;
    bit          pend_v;
    int          pend_id;
    logic [31:0] pend_val;
    logic [31:0] last_rd0, last_rd1;
    bit          exp_oor;

    int          s_g;
    logic        s_rdv0, s_rdv1, s_cs, s_mw, s_oor;
    logic [31:0] s_rd0, s_rd1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_oor(input logic [14:0] a);
        return int'(a) >= DEPTH;
    endfunction

    function automatic req_t mk(input logic rd, input logic wr, input logic [14:0] a,
                                input logic [3:0] be, input logic [31:0] d);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.be = be; r.data = d;
        return r;
    endfunction

    function automatic req_t rnd_req();
        int          k, t;
        logic [14:0] a;
        k = $urandom_range(0, 19);
        if (k < 16)       a = 15'(16'h0100 + $urandom_range(0, 15));
        else if (k == 16) a = 15'(DEPTH - 1);
        else if (k == 17) a = 15'h7FFF;
        else              a = 15'(DEPTH + $urandom_range(0, 3));
        t = $urandom_range(0, 9);
        if (t < 5)                   return mk(1'b1, 1'b0, a, 4'hF, 32'h0);
        if (t == 9 && !is_oor(a))    return mk(1'b1, 1'b1, a, 4'(($urandom_range(1, 15))), $urandom);
        return mk(1'b0, 1'b1, a, 4'(($urandom_range(1, 15))), $urandom);
    endfunction

    task automatic model_reset();
        owner = 1; run = 0; earned = 0; pend_v = 0; pend_id = 0; pend_val = '0;
        last_rd0 = '0; last_rd1 = '0; exp_oor = 0;
`ifdef ONCHIP_MEM_ARB_STATS_EN
        exp_sg0 = 0; exp_sg1 = 0; exp_st = 0;
`endif
    endtask

    task automatic drive_idle();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q0.delete(); q1.delete();
        model_reset();
        drive_idle();
        m0_read = 1'b1;
        m1_write = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_m0_waitrequest", m0_waitrequest, 1);
        check_eq("rst_m1_waitrequest", m1_waitrequest, 1);
        check_eq("rst_mem_chipselect", mem_chipselect, 0);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_m0_readdatavalid", m0_readdatavalid, 0);
        check_eq("rst_m1_readdatavalid", m1_readdatavalid, 0);
        check_eq("rst_m0_readdata", m0_readdata, 0);
        check_eq("rst_m1_readdata", m1_readdata, 0);
        check_eq("rst_oor_err", oor_err, 0);
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive queue heads, compare the DUT with the model, advance the model.
    task automatic step();
        req_t        h;
        int          g;
        bit          r0, r1, oth;
        logic [31:0] e0, e1;
        h = mk(0, 0, '0, '0, '0);
        @(negedge clk);
        r0 = q0.size() > 0;
        r1 = q1.size() > 0;
        drive_idle();
        if (r0) begin
            m0_read = q0[0].rd; m0_write = q0[0].wr; m0_address = q0[0].addr;
            m0_byteenable = q0[0].be; m0_writedata = q0[0].data;
        end
        if (r1) begin
            m1_read = q1[0].rd; m1_write = q1[0].wr; m1_address = q1[0].addr;
            m1_byteenable = q1[0].be; m1_writedata = q1[0].data;
        end
        #1;
        if (r0 && r1) g = (run > 0 && earned && run < MAX_HOLD) ? owner : 1 - owner;
        else if (r0)  g = 0;
        else if (r1)  g = 1;
        else          g = -1;
        if (g == 0) h = q0[0];
        if (g == 1) h = q1[0];

        s_g = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1);
        s_rdv0 = m0_readdatavalid; s_rdv1 = m1_readdatavalid;
        s_rd0 = m0_readdata; s_rd1 = m1_readdata;
        s_cs = mem_chipselect; s_mw = mem_write; s_oor = oor_err;

        check_eq("m0_waitrequest", m0_waitrequest, g != 0);
        check_eq("m1_waitrequest", m1_waitrequest, g != 1);
        check_eq("mem_chipselect", mem_chipselect, g >= 0 && !is_oor(h.addr));
        check_eq("mem_write", mem_write, g >= 0 && h.wr && !is_oor(h.addr));
        check_eq("mem_clken", mem_clken, 1);
        if (g >= 0 && !is_oor(h.addr)) begin
            check_eq("mem_address", mem_address, h.addr);
            if (h.wr) begin
                check_eq("mem_byteenable", mem_byteenable, h.be);
                check_eq("mem_writedata", mem_writedata, h.data);
            end
        end
        e0 = (pend_v && pend_id == 0) ? pend_val : last_rd0;
        e1 = (pend_v && pend_id == 1) ? pend_val : last_rd1;
        check_eq("m0_readdatavalid", m0_readdatavalid, pend_v && pend_id == 0);
        check_eq("m1_readdatavalid", m1_readdatavalid, pend_v && pend_id == 1);
        check_eq("m0_readdata", m0_readdata, e0);
        check_eq("m1_readdata", m1_readdata, e1);
        check_eq("oor_err", oor_err, exp_oor);
`ifdef ONCHIP_MEM_ARB_STATS_EN
        check_eq("stat_grant0", stat_grant0, exp_sg0);
        check_eq("stat_grant1", stat_grant1, exp_sg1);
        check_eq("stat_stall", stat_stall, exp_st);
        if (g == 0) exp_sg0++;
        if (g == 1) exp_sg1++;
        if (r0 && r1) exp_st++;
`endif
        last_rd0 = e0;
        last_rd1 = e1;
        pend_v = 0;
        if (g >= 0) begin
            oth = (g == 0) ? r1 : r0;
            if (g == owner && run > 0) run++;
            else begin
                run = 1;
                earned = !oth;
            end
            owner = g;
            if (h.wr) begin
                if (!is_oor(h.addr))
                    for (int b = 0; b < 4; b++)
                        if (h.be[b]) exp_mem[h.addr][8*b +: 8] = h.data[8*b +: 8];
            end else begin
                pend_v = 1;
                pend_id = g;
                pend_val = is_oor(h.addr) ? 32'h0 : exp_mem[h.addr];
            end
            if (is_oor(h.addr) && !(h.rd && h.wr)) exp_oor = 1;
            if (g == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end else begin
            run = 0;
            earned = 0;
        end
    endtask

    initial begin
        int hold_exp [6];
        hold_exp = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = 32'(i) * 32'h9E3779B1;
            exp_mem[i] = ram[i];
        end
        ram[16'h0010] = 32'h12345678; exp_mem[16'h0010] = 32'h12345678;
        ram[16'h0300] = 32'h0;        exp_mem[16'h0300] = 32'h0;
        drive_idle();
        do_reset();

        // Continuous contention from reset: m0 first, then strict alternation.
        for (int i = 0; i < 6; i++) begin
            q0.push_back(mk(1, 0, 15'(16'h0100 + i), 4'hF, 0));
            q1.push_back(mk(1, 0, 15'(16'h0108 + i), 4'hF, 0));
        end
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq("contention_grant", s_g, i % 2);
        end
        step();

        // Hold window: m0 streams six writes, m1 arrives in cycle 1.
        for (int i = 0; i < 6; i++) q0.push_back(mk(0, 1, 15'(16'h0200 + i), 4'hF, 32'hD000_0000 + i));
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("hold_grant", s_g, hold_exp[i]);
            if (i == 0) q1.push_back(mk(0, 1, 15'h0210, 4'hF, 32'h1111_2222));
        end
        step();

        // Single read with one-cycle latency and data held afterwards.
        q0.push_back(mk(1, 0, 15'h0010, 4'hF, 0));
        step(); check_eq("single_accept", s_g, 0);
        step(); check_eq("single_rdv", s_rdv0, 1); check_eq("single_data", s_rd0, 32'h12345678);
        step(); check_eq("single_rdv_off", s_rdv0, 0); check_eq("single_hold", s_rd0, 32'h12345678);

        // Byte-lane write then readback.
        q1.push_back(mk(0, 1, 15'h0300, 4'b0101, 32'hAABBCCDD));
        q1.push_back(mk(1, 0, 15'h0300, 4'hF, 0));
        step(); step(); step();
        check_eq("byte_rdv", s_rdv1, 1);
        check_eq("byte_data", s_rd1, 32'h00BB00DD);

        // Out of range write and read; boundary word stays in range.
        q0.push_back(mk(0, 1, 15'(DEPTH), 4'hF, 32'hDEADBEEF));
        step(); check_eq("oor_wr_cs", s_cs, 0); check_eq("oor_wr_mw", s_mw, 0); check_eq("oor_pre", s_oor, 0);
        q0.push_back(mk(1, 0, 15'(DEPTH), 4'hF, 0));
        step(); check_eq("oor_rd_cs", s_cs, 0); check_eq("oor_set", s_oor, 1);
        q0.push_back(mk(1, 0, 15'(DEPTH - 1), 4'hF, 0));
        step(); check_eq("oor_rdv", s_rdv0, 1); check_eq("oor_data", s_rd0, 0); check_eq("edge_cs", s_cs, 1);
        step();

        // Read and write together acts as a write with no read return.
        q1.push_back(mk(1, 1, 15'h0301, 4'hF, 32'hCAFEF00D));
        step(); check_eq("rw_as_write", s_mw, 1);
        q1.push_back(mk(1, 0, 15'h0301, 4'hF, 0));
        step(); check_eq("rw_no_rdv", s_rdv1, 0);
        step(); check_eq("rw_readback", s_rd1, 32'hCAFEF00D);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if (q0.size() < 2 && $urandom_range(0, 99) < 55) q0.push_back(rnd_req());
            if (q1.size() < 2 && $urandom_range(0, 99) < 55) q1.push_back(rnd_req());
            step();
        end
        while (q0.size() > 0 || q1.size() > 0) step();
        step();
        check_eq("oor_sticky", oor_err, 1);

        // Reset right after a read is accepted: the return is discarded.
        q0.push_back(mk(1, 0, 15'h0010, 4'hF, 0));
        step();
        @(posedge clk);
        #1;
        do_reset();
        check_eq("rst_rdv_dropped", m0_readdatavalid, 0);
        q0.push_back(mk(1, 0, 15'h0011, 4'hF, 0));
        q1.push_back(mk(1, 0, 15'h0012, 4'hF, 0));
        step(); check_eq("post_rst_tie", s_g, 0);
        step(); check_eq("post_rst_second", s_g, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
